aes_ct_serializer: RTL and testbench



---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_shift_out.sv | 39 +++
 rtl/aes_ct_serializer.sv | 129 ++++++++++++
 tb/tb_aes_ct_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, state enum and FIPS-197 reference vectors for the AES ciphertext serializer.
package aes_pkg;
   localparam int BYTE_W  = 8;
   localparam int BLOCK_W = 128;
   localparam int NBYTES  = BLOCK_W / BYTE_W;
   localparam int CNT_W   = $clog2(NBYTES);

   typedef enum logic {ST_IDLE, ST_SEND} ser_state_t;

   // FIPS-197 Appendix C.1 (AES-128) and Appendix B vectors
   localparam logic [127:0] FIPS_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
endpackage

// File: rtl/aes_shift_out.sv
// Block load/shift register: presents the MS byte, advances one byte per accepted transfer.
// Load has priority over advance; the register clears after the final byte so idle output reads zero.
module aes_shift_out
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst_,
   input  logic               load,
   input  logic [BLOCK_W-1:0] load_dat,
   input  logic               advance,
   output logic [BYTE_W-1:0]  byte_dat,
   output logic               last
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

   logic [BLOCK_W-1:0] sr;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= load_dat;
         cnt <= '0;
      end else if (advance) begin
         if (cnt == CNT_LAST) begin
            sr  <= '0;
            cnt <= '0;
         end else begin
            sr  <= sr << BYTE_W;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign byte_dat = sr[BLOCK_W-1 -: BYTE_W];
   assign last     = (cnt == CNT_LAST);
endmodule

// File: rtl/aes_ct_serializer.sv
// Captures a ciphertext block on the rising edge of ct_valid and streams it MS byte first; first byte 1 cycle after capture,
// holds under dout_ready low. AES_CT_DOUBLE_BUF_EN adds a hold buffer for zero-bubble back-to-back blocks.
module aes_ct_serializer
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst_,
   input  logic [BLOCK_W-1:0] ct_in,
   input  logic               ct_valid,
   output logic               ct_ready,
   output logic [BYTE_W-1:0]  dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               dout_last,
   output logic               busy,
   output logic               overrun
);
   ser_state_t         state, state_nxt;
   logic               ct_q;
   logic               rise;
   logic               xfer;
   logic               last;
   logic               last_xfer;
   logic               load;
   logic [BLOCK_W-1:0] load_dat;

   assign rise       = ct_valid & ~ct_q;
   assign dout_valid = (state == ST_SEND);
   assign busy       = (state == ST_SEND);
   assign xfer       = dout_valid & dout_ready;
   assign last_xfer  = xfer & last;
   assign dout_last  = dout_valid & last;

`ifdef AES_CT_DOUBLE_BUF_EN
   logic [BLOCK_W-1:0] hold_dat;
   logic               hold_full;
   logic               hold_set;
   logic               hold_clr;

   assign ct_ready = ~hold_full;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_dat  = ct_in;
      hold_set  = 1'b0;
      hold_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               load      = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            // A held block takes precedence over one arriving on the same edge
            if (last_xfer) begin
               if (hold_full) begin
                  load     = 1'b1;
                  load_dat = hold_dat;
                  hold_clr = 1'b1;
               end else if (rise) begin
                  load = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (rise && !hold_full) begin
               hold_set = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         hold_dat  <= '0;
         hold_full <= 1'b0;
      end else if (hold_set) begin
         hold_dat  <= ct_in;
         hold_full <= 1'b1;
      end else if (hold_clr) begin
         hold_full <= 1'b0;
      end
   end
`else
   assign ct_ready = (state == ST_IDLE);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_dat  = ct_in;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               load      = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (last_xfer) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state   <= ST_IDLE;
         ct_q    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         ct_q  <= ct_valid;
         if (rise && !ct_ready) overrun <= 1'b1;
      end
   end

   aes_shift_out u_shift_out (
      .clk      (clk),
      .rst_     (rst_),
      .load     (load),
      .load_dat (load_dat),
      .advance  (xfer),
      .byte_dat (dout),
      .last     (last)
   );
endmodule

// File: tb/tb_aes_ct_serializer.sv
// Scoreboard bench for aes_ct_serializer: stimulus queues expected bytes, a negedge monitor checks every transfer.
module tb_aes_ct_serializer;
   import aes_pkg::*;

   typedef struct packed {
      logic [7:0] dat;
      logic       last;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_;
   logic [127:0] ct_in;
   logic         ct_valid;
   logic         ct_ready;
   logic [7:0]   dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         dout_last;
   logic         busy;
   logic         overrun;

   int   checks   = 0;
   int   failures = 0;
   int   xfer_cnt = 0;
   exp_t exp_q[$];

   logic       stall      = 1'b0;
   logic [7:0] held_dat   = '0;
   logic       held_last  = 1'b0;

`ifdef AES_CT_DOUBLE_BUF_EN
   localparam logic SEND_READY = 1'b1;
   localparam int   OVR_CYC    = 27;
   localparam logic OVR_EXP    = 1'b0;
`else
   localparam logic SEND_READY = 1'b0;
   localparam int   OVR_CYC    = 11;
   localparam logic OVR_EXP    = 1'b1;
`endif

   always #5 clk = ~clk;

   aes_ct_serializer dut (
      .clk        (clk),
      .rst_       (rst_),
      .ct_in      (ct_in),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .busy       (busy),
      .overrun    (overrun)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_block(input logic [127:0] d);
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         e.dat  = d[127-8*i -: 8];
         e.last = (i == 15);
         exp_q.push_back(e);
      end
   endtask

   // Entered at a negedge sample point; counts clock edges until busy drops.
   task automatic wait_idle(input logic toggle, output int cyc);
      cyc = 0;
      while (busy) begin
         if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout: got busy after %0d cycles expected idle", cyc);
            break;
         end
         @(posedge clk);
         cyc++;
         #1 if (toggle) dout_ready = ~dout_ready;
         @(negedge clk);
      end
   endtask

   task automatic wait_xfers(input int target);
      int n = 0;
      while (xfer_cnt != target && n < 200) begin
         @(negedge clk);
         #1 n++;
      end
      if (xfer_cnt != target) begin
         checks++;
         failures++;
         $display("FAIL wait_xfers_timeout: got %0d expected %0d", xfer_cnt, target);
      end
   endtask

   task automatic run_block(input logic [127:0] d, input logic toggle, input int exp_cyc, input string name);
      int cyc;
      push_block(d);
      @(negedge clk);
      ct_in = d; ct_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk);
      #1 ct_valid = 1'b0; ct_in = ~d;
      @(negedge clk);
      check({name, "_first_valid"}, dout_valid, 1'b1);
      check({name, "_ready_in_send"}, ct_ready, SEND_READY);
      wait_idle(toggle, cyc);
      check({name, "_cycles"}, cyc + 1, exp_cyc);
      check({name, "_ready_after"}, ct_ready, 1'b1);
   endtask

   // Monitor: predicts each transfer at the negedge before the edge that performs it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_) begin
            stall = 1'b0;
         end else begin
            if (stall && dout_valid) begin
               check("stall_dout", dout, held_dat);
               check("stall_last", dout_last, held_last);
            end
            if (dout_valid && dout_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte: got %0h expected none", dout);
               end else begin
                  e = exp_q.pop_front();
                  check("byte", dout, e.dat);
                  check("byte_last", dout_last, e.last);
               end
               xfer_cnt++;
            end
            stall     = dout_valid && !dout_ready;
            held_dat  = dout;
            held_last = dout_last;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int base;
      rst_ = 1'b0; ct_in = '0; ct_valid = 1'b0; dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ct_ready", ct_ready, 1'b1);
      check("rst_dout_valid", dout_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_dout", dout, 8'h00);
      check("rst_dout_last", dout_last, 1'b0);
      @(negedge clk) rst_ = 1'b1;
      repeat (2) @(negedge clk);

      // Single block, full throughput: ct_ready back on cycle N+17
      run_block(FIPS_CT, 1'b0, 17, "single");
      check("single_idle_dout", dout, 8'h00);

      // Alternating backpressure: 16 transfers over 31 edges
      run_block(FIPS_CT, 1'b1, 32, "bp");

      // Level-held ct_valid yields a single block; ct_in changes after capture are ignored
      push_block(FIPS_B_CT);
      @(negedge clk);
      ct_in = FIPS_B_CT; ct_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk);
      #1 ct_in = FIPS_PT;
      @(negedge clk);
      wait_idle(1'b0, cyc);
      check("held_cycles", cyc + 1, 17);
      repeat (40 - cyc) @(negedge clk);
      ct_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("held_busy", busy, 1'b0);
      check("held_ct_ready", ct_ready, 1'b1);
      check("held_overrun", overrun, 1'b0);
      check("held_queue_empty", exp_q.size(), 0);

      // Second rise while block A streams
      base = xfer_cnt;
      push_block(FIPS_CT);
      @(negedge clk);
      ct_in = FIPS_CT; ct_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk);
      #1 ct_valid = 1'b0;
      wait_xfers(base + 5);
`ifdef AES_CT_DOUBLE_BUF_EN
      push_block(FIPS_B_CT);
`endif
      ct_in = FIPS_B_CT; ct_valid = 1'b1;
      @(posedge clk);
      #1 ct_valid = 1'b0; ct_in = FIPS_PT;
      @(negedge clk);
      wait_idle(1'b0, cyc);
      check("ovr_cycles", cyc, OVR_CYC);
      check("ovr_flag", overrun, OVR_EXP);
      check("ovr_queue_empty", exp_q.size(), 0);

      // Asynchronous reset after 5 transfers discards the rest of the block
      base = xfer_cnt;
      push_block(FIPS_CT);
      @(negedge clk);
      ct_in = FIPS_CT; ct_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk);
      #1 ct_valid = 1'b0;
      wait_xfers(base + 5);
      @(posedge clk);
      #2 rst_ = 1'b0;
      #1;
      check("mid_rst_dout_valid", dout_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_dout", dout, 8'h00);
      check("mid_rst_overrun", overrun, 1'b0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_ = 1'b1;
      @(negedge clk);
      check("post_rst_ct_ready", ct_ready, 1'b1);
      run_block(FIPS_B_CT, 1'b0, 17, "post_rst");
      check("post_rst_overrun", overrun, 1'b0);
      repeat (3) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
